i2s_codec_serdes: RTL



---
 rtl/i2s_codec_serdes.sv | 129 ++++++++++++
 1 files changed

// File: rtl/i2s_codec_serdes.sv
// I2S master serdes for a WM8731-class codec: BCK/LRCK from clk18, stereo DAC serializer, stereo ADC deserializer.
// Optional build macro I2S_LOOPBACK_EN adds a loopback input that feeds aud_dacdat back into the RX shifter.
module i2s_codec_serdes #(
    parameter int unsigned CLK_DIV_HALF = 6,
    parameter int unsigned BITS_PER_CH  = 16
) (
    input  logic                   clk18,
    input  logic                   reset,
    input  logic [BITS_PER_CH-1:0] dac_left,
    input  logic [BITS_PER_CH-1:0] dac_right,
`ifdef I2S_LOOPBACK_EN
    input  logic                   loopback,
`endif
    output logic                   sample_req,
    output logic [BITS_PER_CH-1:0] adc_left,
    output logic [BITS_PER_CH-1:0] adc_right,
    output logic                   adc_valid,
    output logic                   aud_bck,
    output logic                   aud_lrck,
    output logic                   aud_dacdat,
    input  logic                   aud_adcdat
);
    localparam int unsigned DW    = (CLK_DIV_HALF > 1) ? $clog2(CLK_DIV_HALF) : 1;
    localparam int unsigned SLOTS = 2 * BITS_PER_CH;
    localparam int unsigned SW    = $clog2(SLOTS);

    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV_HALF - 1);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(SLOTS - 1);
    localparam logic [SW-1:0] SLOT_FIRST = SW'(1);
    localparam logic [SW-1:0] SLOT_HALF  = SW'(BITS_PER_CH);

    logic [DW-1:0]            r_div;
    logic                     r_bck;
    logic [SW-1:0]            r_slot;
    logic                     r_lrck;
    logic                     r_dacdat;
    logic [SLOTS-2:0]         r_tx_sr;
    logic                     r_sample_req;
    logic [BITS_PER_CH-1:0]   r_rx_sr;
    logic [BITS_PER_CH-1:0]   r_left_latch;
    logic                     r_rx_done;
    logic [BITS_PER_CH-1:0]   r_adc_left;
    logic [BITS_PER_CH-1:0]   r_adc_right;
    logic                     r_adc_valid;

    logic                     w_wrap;
    logic                     w_rise;
    logic                     w_fall;
    logic [SW-1:0]            w_slot_next;
    logic                     w_rx_bit;
    logic [BITS_PER_CH-1:0]   w_rx_next;

    assign w_wrap      = (r_div == DIV_LAST);
    assign w_rise      = w_wrap & ~r_bck;
    assign w_fall      = w_wrap & r_bck;
    assign w_slot_next = (r_slot == SLOT_LAST) ? '0 : r_slot + 1'b1;

`ifdef I2S_LOOPBACK_EN
    assign w_rx_bit = loopback ? r_dacdat : aud_adcdat;
`else
    assign w_rx_bit = aud_adcdat;
`endif

    assign w_rx_next = {r_rx_sr[BITS_PER_CH-2:0], w_rx_bit};

    always_ff @(posedge clk18) begin
        if (reset) begin
            r_div        <= '0;
            r_bck        <= 1'b0;
            r_slot       <= '0;
            r_lrck       <= 1'b0;
            r_dacdat     <= 1'b0;
            r_tx_sr      <= '0;
            r_sample_req <= 1'b0;
            r_rx_sr      <= '0;
            r_left_latch <= '0;
            r_rx_done    <= 1'b0;
            r_adc_left   <= '0;
            r_adc_right  <= '0;
            r_adc_valid  <= 1'b0;
        end else begin
            r_sample_req <= 1'b0;
            r_adc_valid  <= 1'b0;
            r_rx_done    <= 1'b0;

            r_div <= w_wrap ? '0 : r_div + 1'b1;
            if (w_wrap) begin
                r_bck <= ~r_bck;
            end

            // The TX word is split as {r_dacdat, r_tx_sr}: r_dacdat is the MSB of the shifter.
            if (w_fall) begin
                r_slot <= w_slot_next;
                r_lrck <= (w_slot_next >= SLOT_HALF);
                if (w_slot_next == SLOT_FIRST) begin
                    {r_dacdat, r_tx_sr} <= {dac_left, dac_right};
                    r_sample_req        <= 1'b1;
                end else begin
                    {r_dacdat, r_tx_sr} <= {r_tx_sr, 1'b0};
                end
            end

            if (w_rise) begin
                r_rx_sr <= w_rx_next;
                if (r_slot == SLOT_HALF) begin
                    r_left_latch <= w_rx_next;
                end
                if (r_slot == '0) begin
                    r_rx_done <= 1'b1;
                end
            end

            if (r_rx_done) begin
                r_adc_left  <= r_left_latch;
                r_adc_right <= r_rx_sr;
                r_adc_valid <= 1'b1;
            end
        end
    end

    assign sample_req = r_sample_req;
    assign adc_left   = r_adc_left;
    assign adc_right  = r_adc_right;
    assign adc_valid  = r_adc_valid;
    assign aud_bck    = r_bck;
    assign aud_lrck   = r_lrck;
    assign aud_dacdat = r_dacdat;

endmodule
